// File: rtl/dmem_access_ctrl_pkg.sv
// Shared types and defaults for the data-memory access controller.
package dmem_access_ctrl_pkg;

    localparam int unsigned ADDR_W_DEF  = 32;
    localparam int unsigned DATA_W_DEF  = 32;
    localparam int unsigned TIMEOUT_DEF = 15;
    localparam int unsigned CNT_W       = 8;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    // Only word accesses exist, so any nonzero byte offset is misaligned.
    function automatic logic is_misaligned(input logic [1:0] lsb);
        return lsb != 2'b00;
    endfunction

endpackage

// File: rtl/dmem_access_ctrl_wait_timer.sv
// Counts REQ cycles and flags when the ack wait budget is used up.
module dmem_access_ctrl_wait_timer
    import dmem_access_ctrl_pkg::*;
#(
    parameter int unsigned TIMEOUT = TIMEOUT_DEF
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic clear_i,
    input  logic en_i,
    output logic expired_c
);

    logic [CNT_W-1:0] cnt;

    // Wait counter: cleared when a request is launched, advances while waiting.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            cnt <= '0;
        end else if (clear_i) begin
            cnt <= '0;
        end else if (en_i) begin
            cnt <= cnt + CNT_W'(1);
        end
    end

    assign expired_c = (cnt == CNT_W'(TIMEOUT - 1));

endmodule

// File: rtl/dmem_access_ctrl.sv
// Turns MEM-stage loads/stores into one req/ack memory transaction and stalls the pipe meanwhile.
module dmem_access_ctrl
    import dmem_access_ctrl_pkg::*;
#(
    parameter int unsigned ADDR_W  = ADDR_W_DEF,
    parameter int unsigned DATA_W  = DATA_W_DEF,
    parameter int unsigned TIMEOUT = TIMEOUT_DEF
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              MemRead_i,
    input  logic              MemWrite_i,
    input  logic [ADDR_W-1:0] addr_i,
    input  logic [DATA_W-1:0] wdata_i,
    output logic              stall_o,
    output logic [DATA_W-1:0] rdata_o,
    output logic              rdata_valid_o,
    output logic              err_o,
    output logic              mem_req_o,
    output logic              mem_we_o,
    output logic [ADDR_W-1:0] mem_addr_o,
    output logic [DATA_W-1:0] mem_wdata_o,
    input  logic              mem_ack_i,
    input  logic [DATA_W-1:0] mem_rdata_i
);

    state_t              state;
    state_t              state_nxt;
    logic                access_c;
    logic                illegal_c;
    logic                req_nxt;
    logic                valid_nxt;
    logic                err_nxt;
    logic [DATA_W-1:0]   rdata_nxt;
    logic                load_c;
    logic                timer_clr_c;
    logic                timer_en_c;
    logic                expired_c;

    assign access_c   = MemRead_i | MemWrite_i;
    assign illegal_c  = is_misaligned(addr_i[1:0]) | (MemRead_i & MemWrite_i);
    assign timer_en_c = (state == ST_REQ);

    dmem_access_ctrl_wait_timer #(
        .TIMEOUT   (TIMEOUT)
    ) u_wait_timer (
        .clk_i     (clk_i),
        .rst_i     (rst_i),
        .clear_i   (timer_clr_c),
        .en_i      (timer_en_c),
        .expired_c (expired_c)
    );

    // Next state, registered-output next values and the combinational stall.
    always_comb begin
        state_nxt   = state;
        req_nxt     = 1'b0;
        valid_nxt   = 1'b0;
        err_nxt     = 1'b0;
        rdata_nxt   = rdata_o;
        load_c      = 1'b0;
        timer_clr_c = 1'b0;
        stall_o     = 1'b0;
        case (state)
            ST_IDLE: begin
                stall_o = access_c;
                if (access_c) begin
                    if (illegal_c) begin
                        // Rejected without touching memory; load data is zeroed on any error.
                        state_nxt = ST_DONE;
                        err_nxt   = 1'b1;
                        rdata_nxt = '0;
                    end else begin
                        state_nxt   = ST_REQ;
                        req_nxt     = 1'b1;
                        load_c      = 1'b1;
                        timer_clr_c = 1'b1;
                    end
                end
            end
            ST_REQ: begin
                stall_o = 1'b1;
                if (mem_ack_i) begin
                    state_nxt = ST_DONE;
                    if (!mem_we_o) begin
                        valid_nxt = 1'b1;
                        rdata_nxt = mem_rdata_i;
                    end
                end else if (expired_c) begin
                    state_nxt = ST_DONE;
                    err_nxt   = 1'b1;
                    rdata_nxt = '0;
                end else begin
                    req_nxt = 1'b1;
                end
            end
            ST_DONE: begin
                // Inputs still belong to the retiring instruction; never start here.
                state_nxt = ST_IDLE;
            end
            default: begin
                state_nxt = ST_IDLE;
            end
        endcase
    end

    // State and output registers; reset drops an in-flight request immediately.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state         <= ST_IDLE;
            mem_req_o     <= 1'b0;
            mem_we_o      <= 1'b0;
            mem_addr_o    <= '0;
            mem_wdata_o   <= '0;
            rdata_o       <= '0;
            rdata_valid_o <= 1'b0;
            err_o         <= 1'b0;
        end else begin
            state         <= state_nxt;
            mem_req_o     <= req_nxt;
            rdata_o       <= rdata_nxt;
            rdata_valid_o <= valid_nxt;
            err_o         <= err_nxt;
            if (load_c) begin
                mem_we_o    <= MemWrite_i;
                mem_addr_o  <= addr_i;
                mem_wdata_o <= wdata_i;
            end
        end
    end

endmodule

// File: tb/tb_dmem_access_ctrl.sv
// Self-checking bench for dmem_access_ctrl against a transaction-level reference model.
module tb_dmem_access_ctrl;

    localparam int unsigned ADDR_W  = 32;
    localparam int unsigned DATA_W  = 32;
    localparam int unsigned TIMEOUT = 15;

    logic              clk_i = 1'b0;
    logic              rst_i = 1'b1;
    logic              MemRead_i = 1'b0;
    logic              MemWrite_i = 1'b0;
    logic [ADDR_W-1:0] addr_i = '0;
    logic [DATA_W-1:0] wdata_i = '0;
    logic              stall_o;
    logic [DATA_W-1:0] rdata_o;
    logic              rdata_valid_o;
    logic              err_o;
    logic              mem_req_o;
    logic              mem_we_o;
    logic [ADDR_W-1:0] mem_addr_o;
    logic [DATA_W-1:0] mem_wdata_o;
    logic              mem_ack_i = 1'b0;
    logic [DATA_W-1:0] mem_rdata_i = '0;

    int checks = 0;
    int errors = 0;

    // Observations gathered by do_access for the calling test to judge.
    int          obs_stall, obs_req, obs_err, obs_valid, obs_unstable;
    bit          obs_timeout;
    logic [31:0] obs_rdata_done, obs_addr, obs_wdata;
    logic        obs_we;
    logic [31:0] exp_rdata = '0;

    dmem_access_ctrl #(
        .ADDR_W        (ADDR_W),
        .DATA_W        (DATA_W),
        .TIMEOUT       (TIMEOUT)
    ) dut (
        .clk_i         (clk_i),
        .rst_i         (rst_i),
        .MemRead_i     (MemRead_i),
        .MemWrite_i    (MemWrite_i),
        .addr_i        (addr_i),
        .wdata_i       (wdata_i),
        .stall_o       (stall_o),
        .rdata_o       (rdata_o),
        .rdata_valid_o (rdata_valid_o),
        .err_o         (err_o),
        .mem_req_o     (mem_req_o),
        .mem_we_o      (mem_we_o),
        .mem_addr_o    (mem_addr_o),
        .mem_wdata_o   (mem_wdata_o),
        .mem_ack_i     (mem_ack_i),
        .mem_rdata_i   (mem_rdata_i)
    );

    always #5 clk_i = ~clk_i;

    initial begin
        #2000000;
        $display("FAIL watchdog simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Reference: outcome of one instruction given the memory's ack delay (0 = ack on first request cycle).
    function automatic void model(input logic rd, input logic wr, input logic [31:0] a, input int dly,
                                  output int e_req, output int e_stall, output int e_err, output int e_valid);
        bit illegal;
        illegal = (a % 4 != 0) || (rd && wr);
        e_valid = 0;
        if (illegal) begin
            e_req = 0; e_stall = 1; e_err = 1;
        end else if (dly < int'(TIMEOUT)) begin
            e_req = dly + 1; e_stall = dly + 2; e_err = 0; e_valid = rd ? 1 : 0;
        end else begin
            e_req = TIMEOUT; e_stall = TIMEOUT + 1; e_err = 1;
        end
    endfunction

    // Presents one instruction (called just after a falling edge) until the pipeline advances past it.
    task automatic do_access(input logic rd, input logic wr, input logic [31:0] a, input logic [31:0] wd,
                             input int dly, input logic [31:0] md, input bit stray);
        int reqn;
        bit done;
        reqn = 0; done = 0;
        obs_stall = 0; obs_err = 0; obs_valid = 0; obs_unstable = 0;
        obs_rdata_done = '0; obs_addr = '0; obs_wdata = '0; obs_we = 1'b0;
        MemRead_i = rd; MemWrite_i = wr; addr_i = a; wdata_i = wd;
        for (int cyc = 0; cyc < 64 && !done; cyc++) begin
            if (mem_req_o) mem_ack_i = (reqn == dly);
            else           mem_ack_i = stray && ($urandom_range(0, 1) == 1);
            mem_rdata_i = mem_ack_i ? md : DATA_W'($urandom);
            #1;
            if (stall_o) obs_stall++;
            if (mem_req_o) begin
                if (reqn == 0) begin
                    obs_addr = mem_addr_o; obs_we = mem_we_o; obs_wdata = mem_wdata_o;
                end else if (mem_addr_o !== obs_addr || mem_we_o !== obs_we || mem_wdata_o !== obs_wdata) begin
                    obs_unstable++;
                end
                reqn++;
            end
            if (err_o) obs_err++;
            if (rdata_valid_o) obs_valid++;
            if (cyc > 0 && !stall_o) begin
                done = 1;
                obs_rdata_done = rdata_o;
            end
            @(negedge clk_i);
        end
        mem_ack_i = 1'b0;
        obs_req = reqn;
        obs_timeout = !done;
    endtask

    task automatic test_reset();
        @(negedge clk_i);
        @(negedge clk_i);
        checks++; if (mem_req_o !== 1'b0) begin errors++; $display("FAIL reset_req got %b exp 0", mem_req_o); end
        checks++; if (stall_o !== 1'b0) begin errors++; $display("FAIL reset_stall got %b exp 0", stall_o); end
        checks++; if (rdata_valid_o !== 1'b0) begin errors++; $display("FAIL reset_valid got %b exp 0", rdata_valid_o); end
        checks++; if (err_o !== 1'b0) begin errors++; $display("FAIL reset_err got %b exp 0", err_o); end
        checks++; if (rdata_o !== 32'h0) begin errors++; $display("FAIL reset_rdata got %h exp 0", rdata_o); end
        checks++; if (mem_we_o !== 1'b0) begin errors++; $display("FAIL reset_we got %b exp 0", mem_we_o); end
        checks++; if (mem_addr_o !== 32'h0) begin errors++; $display("FAIL reset_addr got %h exp 0", mem_addr_o); end
        checks++; if (mem_wdata_o !== 32'h0) begin errors++; $display("FAIL reset_wdata got %h exp 0", mem_wdata_o); end
        rst_i = 1'b0;
        @(negedge clk_i);
    endtask

    task automatic test_load();
        do_access(1'b1, 1'b0, 32'h10, 32'h0, 2, 32'hDEADBEEF, 1'b0);
        exp_rdata = 32'hDEADBEEF;
        checks++; if (obs_timeout) begin errors++; $display("FAIL load_done got timeout exp completion"); end
        checks++; if (obs_stall !== 4) begin errors++; $display("FAIL load_stall got %0d exp 4", obs_stall); end
        checks++; if (obs_req !== 3) begin errors++; $display("FAIL load_req got %0d exp 3", obs_req); end
        checks++; if (obs_valid !== 1) begin errors++; $display("FAIL load_valid got %0d exp 1", obs_valid); end
        checks++; if (obs_rdata_done !== exp_rdata) begin errors++; $display("FAIL load_rdata got %h exp %h", obs_rdata_done, exp_rdata); end
        checks++; if (obs_we !== 1'b0) begin errors++; $display("FAIL load_we got %b exp 0", obs_we); end
        checks++; if (obs_addr !== 32'h10) begin errors++; $display("FAIL load_addr got %h exp 10", obs_addr); end
        checks++; if (obs_unstable !== 0) begin errors++; $display("FAIL load_stable got %0d exp 0", obs_unstable); end
    endtask

    task automatic test_store();
        do_access(1'b0, 1'b1, 32'h20, 32'h12345678, 0, 32'hFFFF0000, 1'b0);
        checks++; if (obs_stall !== 2) begin errors++; $display("FAIL store_stall got %0d exp 2", obs_stall); end
        checks++; if (obs_req !== 1) begin errors++; $display("FAIL store_req got %0d exp 1", obs_req); end
        checks++; if (obs_we !== 1'b1) begin errors++; $display("FAIL store_we got %b exp 1", obs_we); end
        checks++; if (obs_addr !== 32'h20) begin errors++; $display("FAIL store_addr got %h exp 20", obs_addr); end
        checks++; if (obs_wdata !== 32'h12345678) begin errors++; $display("FAIL store_wdata got %h exp 12345678", obs_wdata); end
        checks++; if (obs_valid !== 0) begin errors++; $display("FAIL store_valid got %0d exp 0", obs_valid); end
        checks++; if (obs_rdata_done !== exp_rdata) begin errors++; $display("FAIL store_rdata_kept got %h exp %h", obs_rdata_done, exp_rdata); end
    endtask

    task automatic test_misaligned();
        do_access(1'b1, 1'b0, 32'h13, 32'h0, 0, 32'h11111111, 1'b1);
        exp_rdata = '0;
        checks++; if (obs_req !== 0) begin errors++; $display("FAIL misal_req got %0d exp 0", obs_req); end
        checks++; if (obs_stall !== 1) begin errors++; $display("FAIL misal_stall got %0d exp 1", obs_stall); end
        checks++; if (obs_err !== 1) begin errors++; $display("FAIL misal_err got %0d exp 1", obs_err); end
        checks++; if (obs_valid !== 0) begin errors++; $display("FAIL misal_valid got %0d exp 0", obs_valid); end
        checks++; if (obs_rdata_done !== exp_rdata) begin errors++; $display("FAIL misal_rdata got %h exp %h", obs_rdata_done, exp_rdata); end
        do_access(1'b1, 1'b1, 32'h24, 32'h0, 0, 32'h22222222, 1'b0);
        checks++; if (obs_req !== 0) begin errors++; $display("FAIL both_req got %0d exp 0", obs_req); end
        checks++; if (obs_err !== 1) begin errors++; $display("FAIL both_err got %0d exp 1", obs_err); end
    endtask

    task automatic test_timeout();
        do_access(1'b1, 1'b0, 32'h2C, 32'h0, 0, 32'h55AA55AA, 1'b0);
        exp_rdata = 32'h55AA55AA;
        checks++; if (obs_rdata_done !== exp_rdata) begin errors++; $display("FAIL pre_to_rdata got %h exp %h", obs_rdata_done, exp_rdata); end
        do_access(1'b1, 1'b0, 32'h30, 32'h0, 1000, 32'h0, 1'b0);
        exp_rdata = '0;
        checks++; if (obs_req !== int'(TIMEOUT)) begin errors++; $display("FAIL to_req got %0d exp %0d", obs_req, TIMEOUT); end
        checks++; if (obs_stall !== int'(TIMEOUT) + 1) begin errors++; $display("FAIL to_stall got %0d exp %0d", obs_stall, TIMEOUT + 1); end
        checks++; if (obs_err !== 1) begin errors++; $display("FAIL to_err got %0d exp 1", obs_err); end
        checks++; if (obs_valid !== 0) begin errors++; $display("FAIL to_valid got %0d exp 0", obs_valid); end
        checks++; if (obs_rdata_done !== exp_rdata) begin errors++; $display("FAIL to_rdata got %h exp 0", obs_rdata_done); end
        checks++; if (obs_unstable !== 0) begin errors++; $display("FAIL to_stable got %0d exp 0", obs_unstable); end
        MemRead_i = 1'b0; MemWrite_i = 1'b0;
        #1;
        checks++; if (mem_req_o !== 1'b0 || stall_o !== 1'b0) begin errors++; $display("FAIL to_idle got req=%b stall=%b exp 0 0", mem_req_o, stall_o); end
        @(negedge clk_i);
    endtask

    task automatic test_reset_mid();
        MemRead_i = 1'b1; MemWrite_i = 1'b0; addr_i = 32'h40; mem_ack_i = 1'b0;
        @(negedge clk_i);
        #1;
        checks++; if (mem_req_o !== 1'b1) begin errors++; $display("FAIL rstmid_req1 got %b exp 1", mem_req_o); end
        @(negedge clk_i);
        rst_i = 1'b1; MemRead_i = 1'b0;
        #1;
        exp_rdata = '0;
        checks++; if (mem_req_o !== 1'b0) begin errors++; $display("FAIL rstmid_req got %b exp 0", mem_req_o); end
        checks++; if (stall_o !== 1'b0 || err_o !== 1'b0 || rdata_valid_o !== 1'b0) begin
            errors++; $display("FAIL rstmid_outs got stall=%b err=%b valid=%b exp 0 0 0", stall_o, err_o, rdata_valid_o); end
        @(negedge clk_i);
        rst_i = 1'b0; mem_ack_i = 1'b1; mem_rdata_i = 32'hBAD0BAD0;
        @(negedge clk_i);
        mem_ack_i = 1'b0;
        #1;
        checks++; if (rdata_valid_o !== 1'b0 || mem_req_o !== 1'b0 || err_o !== 1'b0) begin
            errors++; $display("FAIL late_ack got valid=%b req=%b err=%b exp 0 0 0", rdata_valid_o, mem_req_o, err_o); end
        checks++; if (rdata_o !== exp_rdata) begin errors++; $display("FAIL late_ack_rdata got %h exp %h", rdata_o, exp_rdata); end
        @(negedge clk_i);
        do_access(1'b1, 1'b0, 32'h44, 32'h0, 1, 32'hCAFEF00D, 1'b0);
        exp_rdata = 32'hCAFEF00D;
        checks++; if (obs_valid !== 1 || obs_rdata_done !== exp_rdata) begin
            errors++; $display("FAIL post_rst_load got valid=%0d rdata=%h exp 1 %h", obs_valid, obs_rdata_done, exp_rdata); end
    endtask

    task automatic test_back_to_back();
        int req_tot, stall_tot, valid_tot;
        do_access(1'b1, 1'b0, 32'h50, 32'h0, 1, 32'hA5A50001, 1'b0);
        exp_rdata = 32'hA5A50001;
        checks++; if (obs_req !== 2 || obs_valid !== 1) begin errors++; $display("FAIL b2b_load got req=%0d valid=%0d exp 2 1", obs_req, obs_valid); end
        do_access(1'b0, 1'b1, 32'h54, 32'h0BADCAFE, 1, 32'h0, 1'b0);
        checks++; if (obs_req !== 2 || obs_we !== 1'b1) begin errors++; $display("FAIL b2b_store got req=%0d we=%b exp 2 1", obs_req, obs_we); end
        checks++; if (obs_addr !== 32'h54 || obs_wdata !== 32'h0BADCAFE) begin errors++; $display("FAIL b2b_store_bus got %h %h exp 54 0badcafe", obs_addr, obs_wdata); end
        checks++; if (obs_rdata_done !== exp_rdata) begin errors++; $display("FAIL b2b_rdata got %h exp %h", obs_rdata_done, exp_rdata); end
        MemRead_i = 1'b0; MemWrite_i = 1'b0;
        req_tot = 0; stall_tot = 0; valid_tot = 0;
        for (int i = 0; i < 4; i++) begin
            mem_ack_i = ($urandom_range(0, 1) == 1);
            #1;
            if (mem_req_o) req_tot++;
            if (stall_o) stall_tot++;
            if (rdata_valid_o) valid_tot++;
            @(negedge clk_i);
        end
        mem_ack_i = 1'b0;
        checks++; if (req_tot !== 0 || stall_tot !== 0 || valid_tot !== 0) begin
            errors++; $display("FAIL b2b_idle got req=%0d stall=%0d valid=%0d exp 0 0 0", req_tot, stall_tot, valid_tot); end
    endtask

    task automatic test_random();
        int e_req, e_stall, e_err, e_valid, dly, kind;
        logic rd, wr;
        logic [31:0] a, wd, md;
        for (int n = 0; n < 40; n++) begin
            kind = $urandom_range(0, 4);
            rd = (kind == 0 || kind == 2 || kind == 3);
            wr = (kind == 1 || kind == 2 || kind == 4);
            a = $urandom;
            if ($urandom_range(0, 3) != 0) a[1:0] = 2'b00;
            wd = $urandom; md = $urandom;
            dly = $urandom_range(0, 17);
            model(rd, wr, a, dly, e_req, e_stall, e_err, e_valid);
            do_access(rd, wr, a, wd, dly, md, 1'b1);
            if (e_valid != 0) exp_rdata = md;
            else if (e_err != 0) exp_rdata = '0;
            checks++; if (obs_stall !== e_stall) begin errors++; $display("FAIL rnd%0d_stall got %0d exp %0d", n, obs_stall, e_stall); end
            checks++; if (obs_req !== e_req) begin errors++; $display("FAIL rnd%0d_req got %0d exp %0d", n, obs_req, e_req); end
            checks++; if (obs_err !== e_err) begin errors++; $display("FAIL rnd%0d_err got %0d exp %0d", n, obs_err, e_err); end
            checks++; if (obs_valid !== e_valid) begin errors++; $display("FAIL rnd%0d_valid got %0d exp %0d", n, obs_valid, e_valid); end
            checks++; if (obs_rdata_done !== exp_rdata) begin errors++; $display("FAIL rnd%0d_rdata got %h exp %h", n, obs_rdata_done, exp_rdata); end
            checks++; if (obs_unstable !== 0) begin errors++; $display("FAIL rnd%0d_stable got %0d exp 0", n, obs_unstable); end
            if (e_req > 0) begin
                checks++; if (obs_addr !== a || obs_we !== wr) begin errors++; $display("FAIL rnd%0d_bus got %h/%b exp %h/%b", n, obs_addr, obs_we, a, wr); end
                if (wr) begin
                    checks++; if (obs_wdata !== wd) begin errors++; $display("FAIL rnd%0d_wdata got %h exp %h", n, obs_wdata, wd); end
                end
            end
            if ($urandom_range(0, 3) == 0) begin
                MemRead_i = 1'b0; MemWrite_i = 1'b0;
                #1;
                checks++; if (stall_o !== 1'b0 || mem_req_o !== 1'b0) begin errors++; $display("FAIL rnd%0d_bubble got stall=%b req=%b exp 0 0", n, stall_o, mem_req_o); end
                @(negedge clk_i);
            end
        end
    endtask

    initial begin
        test_reset();
        test_load();
        test_store();
        test_misaligned();
        test_timeout();
        test_reset_mid();
        test_back_to_back();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
